// File: rtl/axis_get_field.sv
// axis_get_field: forwards an AXI-Stream packet through a one-stage register
// slice and, from the first beat of each packet, extracts a fixed bit field
// (plus the packet tid) into a small FIFO presented as a separate field stream.
module axis_get_field #(
    parameter int DATA_WIDTH       = 600,
    parameter int KEEP_WIDTH       = DATA_WIDTH / 8,
    parameter int ID_WIDTH         = 8,
    parameter int DEST_WIDTH       = 4,
    parameter int USER_WIDTH       = 6,
    parameter int GET_DATA_WIDTH   = 8,
    parameter int GET_ADDR_OFFSET  = 0,
    parameter int FIELD_FIFO_DEPTH = 4
) (
    input  logic                                clk,
    input  logic                                rst,

    input  logic [DATA_WIDTH-1:0]               s_axis_tdata,
    input  logic [KEEP_WIDTH-1:0]               s_axis_tkeep,
    input  logic                                s_axis_tvalid,
    output logic                                s_axis_tready,
    input  logic                                s_axis_tlast,
    input  logic [ID_WIDTH-1:0]                 s_axis_tid,
    input  logic [DEST_WIDTH-1:0]               s_axis_tdest,
    input  logic [USER_WIDTH-1:0]               s_axis_tuser,

    output logic [DATA_WIDTH-1:0]               m_axis_tdata,
    output logic [KEEP_WIDTH-1:0]               m_axis_tkeep,
    output logic                                m_axis_tvalid,
    input  logic                                m_axis_tready,
    output logic                                m_axis_tlast,
    output logic [ID_WIDTH-1:0]                 m_axis_tid,
    output logic [DEST_WIDTH-1:0]               m_axis_tdest,
    output logic [USER_WIDTH-1:0]               m_axis_tuser,

    output logic [GET_DATA_WIDTH-1:0]           m_field_tdata,
    output logic [ID_WIDTH-1:0]                 m_field_tid,
    output logic                                m_field_tvalid,
    input  logic                                m_field_tready,

    output logic [$clog2(FIELD_FIFO_DEPTH):0]   field_count
);

    localparam int ADDR_W  = $clog2(FIELD_FIFO_DEPTH);
    localparam int PTR_W   = ADDR_W + 1;
    localparam int ENTRY_W = GET_DATA_WIDTH + ID_WIDTH;

    // Parameter sanity: a field outside the bus or a non power-of-2 FIFO
    // would silently misbehave, so refuse to elaborate.
    if (GET_ADDR_OFFSET + GET_DATA_WIDTH > DATA_WIDTH) begin : g_bad_field
        $error("axis_get_field: field [%0d +: %0d] exceeds DATA_WIDTH %0d",
               GET_ADDR_OFFSET, GET_DATA_WIDTH, DATA_WIDTH);
    end
    if (FIELD_FIFO_DEPTH < 2 || (FIELD_FIFO_DEPTH & (FIELD_FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("axis_get_field: FIELD_FIFO_DEPTH %0d must be a power of 2 and >= 2",
               FIELD_FIFO_DEPTH);
    end

    logic [DATA_WIDTH-1:0] tdata_p0;
    logic [KEEP_WIDTH-1:0] tkeep_p0;
    logic                  tlast_p0;
    logic [ID_WIDTH-1:0]   tid_p0;
    logic [DEST_WIDTH-1:0] tdest_p0;
    logic [USER_WIDTH-1:0] tuser_p0;
    logic                  vld_p0;

    logic                  first_beat;
    logic [PTR_W-1:0]      wr_ptr;
    logic [PTR_W-1:0]      rd_ptr;
    logic [ENTRY_W-1:0]    mem [FIELD_FIFO_DEPTH];

    logic                  fifo_full;
    logic                  accept;
    logic                  push;
    logic                  pop;
    logic [ENTRY_W-1:0]    rd_entry;

    // Full is derived from registered pointers only, so a same-cycle pop can
    // never open the input for a first beat; the push waits one cycle instead.
    assign fifo_full     = (wr_ptr[PTR_W-1] != rd_ptr[PTR_W-1]) &&
                           (wr_ptr[ADDR_W-1:0] == rd_ptr[ADDR_W-1:0]);
    assign s_axis_tready = (!vld_p0 || m_axis_tready) && !(first_beat && fifo_full);
    assign accept        = s_axis_tvalid && s_axis_tready;
    assign push          = accept && first_beat;
    assign pop           = m_field_tvalid && m_field_tready;

    // Stage p0: forwarding register slice, loads on every accepted beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_p0   <= 1'b0;
            tdata_p0 <= '0;
            tkeep_p0 <= '0;
            tlast_p0 <= 1'b0;
            tid_p0   <= '0;
            tdest_p0 <= '0;
            tuser_p0 <= '0;
        end else if (accept) begin
            vld_p0   <= 1'b1;
            tdata_p0 <= s_axis_tdata;
            tkeep_p0 <= s_axis_tkeep;
            tlast_p0 <= s_axis_tlast;
            tid_p0   <= s_axis_tid;
            tdest_p0 <= s_axis_tdest;
            tuser_p0 <= s_axis_tuser;
        end else if (m_axis_tready) begin
            vld_p0   <= 1'b0;
        end
    end

    assign m_axis_tdata  = tdata_p0;
    assign m_axis_tkeep  = tkeep_p0;
    assign m_axis_tlast  = tlast_p0;
    assign m_axis_tid    = tid_p0;
    assign m_axis_tdest  = tdest_p0;
    assign m_axis_tuser  = tuser_p0;
    assign m_axis_tvalid = vld_p0;

    // Track packet boundaries: the beat after an accepted tlast is a first beat.
    always_ff @(posedge clk) begin
        if (rst) begin
            first_beat <= 1'b1;
        end else if (accept) begin
            first_beat <= s_axis_tlast;
        end
    end

    // Field FIFO storage: one entry written per packet, on its first beat.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr[ADDR_W-1:0]] <= {s_axis_tdata[GET_ADDR_OFFSET +: GET_DATA_WIDTH], s_axis_tid};
        end
    end

    // Field FIFO pointers with a wrap bit to tell full from empty.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
        end
    end

    assign rd_entry       = mem[rd_ptr[ADDR_W-1:0]];
    assign field_count    = wr_ptr - rd_ptr;
    assign m_field_tvalid = (wr_ptr != rd_ptr);
    assign m_field_tdata  = rd_entry[ENTRY_W-1:ID_WIDTH];
    assign m_field_tid    = rd_entry[ID_WIDTH-1:0];

endmodule

// File: tb/tb_axis_get_field.sv
// Directed bench for axis_get_field with a 64-bit bus and an 8-bit field at
// bit 16, field FIFO depth 4.
module tb_axis_get_field;

    localparam int DW = 64;
    localparam int KW = DW / 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] s_tdata;
    logic [KW-1:0] s_tkeep;
    logic          s_tvalid;
    logic          s_tready;
    logic          s_tlast;
    logic [7:0]    s_tid;
    logic [3:0]    s_tdest;
    logic [5:0]    s_tuser;
    logic [DW-1:0] m_tdata;
    logic [KW-1:0] m_tkeep;
    logic          m_tvalid;
    logic          m_tready;
    logic          m_tlast;
    logic [7:0]    m_tid;
    logic [3:0]    m_tdest;
    logic [5:0]    m_tuser;
    logic [7:0]    f_tdata;
    logic [7:0]    f_tid;
    logic          f_tvalid;
    logic          f_tready;
    logic [2:0]    f_count;

    int pass_cnt  = 0;
    int total_cnt = 0;

    axis_get_field #(
        .DATA_WIDTH(DW), .KEEP_WIDTH(KW), .ID_WIDTH(8), .DEST_WIDTH(4),
        .USER_WIDTH(6), .GET_DATA_WIDTH(8), .GET_ADDR_OFFSET(16),
        .FIELD_FIFO_DEPTH(4)
    ) dut (
        .clk(clk), .rst(rst),
        .s_axis_tdata(s_tdata), .s_axis_tkeep(s_tkeep), .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready), .s_axis_tlast(s_tlast), .s_axis_tid(s_tid),
        .s_axis_tdest(s_tdest), .s_axis_tuser(s_tuser),
        .m_axis_tdata(m_tdata), .m_axis_tkeep(m_tkeep), .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready), .m_axis_tlast(m_tlast), .m_axis_tid(m_tid),
        .m_axis_tdest(m_tdest), .m_axis_tuser(m_tuser),
        .m_field_tdata(f_tdata), .m_field_tid(f_tid), .m_field_tvalid(f_tvalid),
        .m_field_tready(f_tready), .field_count(f_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) begin
            pass_cnt++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one beat, confirm it is ready, let it be accepted.
    task automatic beat(input logic [63:0] d, input logic [7:0] id, input logic last);
        s_tdata  = d;
        s_tid    = id;
        s_tlast  = last;
        s_tvalid = 1'b1;
        #1;
        chk("beat_ready", 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0;
    endtask

    function automatic logic [63:0] mk(input logic [31:0] hi, input logic [7:0] f, input logic [15:0] lo);
        return {hi, 8'h00, f, lo};
    endfunction

    initial begin
        rst      = 1'b1;
        s_tdata  = '0;
        s_tkeep  = '1;
        s_tvalid = 1'b0;
        s_tlast  = 1'b0;
        s_tid    = '0;
        s_tdest  = '0;
        s_tuser  = '0;
        m_tready = 1'b1;
        f_tready = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        #1;

        // Reset state
        chk("rst_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rst_f_tvalid", 64'(f_tvalid), 64'd0);
        chk("rst_count",    64'(f_count),  64'd0);
        chk("rst_m_tdata",  m_tdata,       64'd0);
        chk("rst_s_tready", 64'(s_tready), 64'd1);

        // Single 3-beat packet
        s_tkeep = 8'hF0; s_tdest = 4'hA; s_tuser = 6'h2B;
        beat(64'h0000_0000_00AB_0000, 8'd5, 1'b0);
        chk("p1_b0_data",  m_tdata, 64'h0000_0000_00AB_0000);
        chk("p1_b0_keep",  64'(m_tkeep), 64'hF0);
        chk("p1_b0_dest",  64'(m_tdest), 64'hA);
        chk("p1_b0_user",  64'(m_tuser), 64'h2B);
        chk("p1_b0_tid",   64'(m_tid),   64'd5);
        chk("p1_f_valid",  64'(f_tvalid), 64'd1);
        chk("p1_f_data",   64'(f_tdata),  64'hAB);
        chk("p1_f_tid",    64'(f_tid),    64'd5);
        s_tkeep = 8'hFF;
        beat(mk(32'hDEAD_BEEF, 8'hFF, 16'h1111), 8'd5, 1'b0);
        chk("p1_b1_data",  m_tdata, mk(32'hDEAD_BEEF, 8'hFF, 16'h1111));
        chk("p1_b1_last",  64'(m_tlast), 64'd0);
        chk("p1_f_popped", 64'(f_tvalid), 64'd0);
        beat(mk(32'hCAFE_F00D, 8'hFF, 16'h2222), 8'd5, 1'b1);
        chk("p1_b2_data",  m_tdata, mk(32'hCAFE_F00D, 8'hFF, 16'h2222));
        chk("p1_b2_last",  64'(m_tlast), 64'd1);
        chk("p1_one_field", 64'(f_count), 64'd0);
        tick();
        chk("p1_idle_m_tvalid", 64'(m_tvalid), 64'd0);

        // Back-to-back single-beat packets, fields held then drained in order
        f_tready = 1'b0;
        beat(mk(32'h0, 8'h11, 16'h0), 8'd1, 1'b1);
        beat(mk(32'h0, 8'h22, 16'h0), 8'd2, 1'b1);
        beat(mk(32'h0, 8'h33, 16'h0), 8'd3, 1'b1);
        chk("b2b_count", 64'(f_count), 64'd3);
        chk("b2b_f0",    64'(f_tdata), 64'h11);
        chk("b2b_t0",    64'(f_tid),   64'd1);
        f_tready = 1'b1;
        tick();
        chk("b2b_f1",    64'(f_tdata), 64'h22);
        chk("b2b_t1",    64'(f_tid),   64'd2);
        tick();
        chk("b2b_f2",    64'(f_tdata), 64'h33);
        chk("b2b_t2",    64'(f_tid),   64'd3);
        tick();
        chk("b2b_empty", 64'(f_tvalid), 64'd0);
        chk("b2b_count0", 64'(f_count), 64'd0);

        // Field backpressure: fill the FIFO, stall the 5th first beat
        f_tready = 1'b0;
        beat(mk(32'h0, 8'h41, 16'h0), 8'h11, 1'b1);
        beat(mk(32'h0, 8'h42, 16'h0), 8'h12, 1'b1);
        beat(mk(32'h0, 8'h43, 16'h0), 8'h13, 1'b1);
        beat(mk(32'h0, 8'h44, 16'h0), 8'h14, 1'b1);
        chk("bp_count4", 64'(f_count), 64'd4);
        s_tdata  = mk(32'h5555_0000, 8'h45, 16'h0);
        s_tid    = 8'h15;
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        #1;
        chk("bp_stall", 64'(s_tready), 64'd0);
        tick();
        chk("bp_stall_count", 64'(f_count),  64'd4);
        chk("bp_stall_hold",  64'(s_tready), 64'd0);
        f_tready = 1'b1;
        tick();
        f_tready = 1'b0;
        chk("bp_count3", 64'(f_count),  64'd3);
        chk("bp_unstall", 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0;
        chk("bp_count4b", 64'(f_count), 64'd4);
        chk("bp_5th_fwd", m_tdata, mk(32'h5555_0000, 8'h45, 16'h0));

        // Mid-packet beats pass while the FIFO is full
        f_tready = 1'b1;
        tick();
        f_tready = 1'b0;
        chk("mp_count3", 64'(f_count), 64'd3);
        beat(mk(32'h1, 8'h4F, 16'h0), 8'd7, 1'b0);
        chk("mp_full", 64'(f_count), 64'd4);
        beat(mk(32'h2, 8'hEE, 16'h0), 8'd7, 1'b0);
        beat(mk(32'h3, 8'hEE, 16'h0), 8'd7, 1'b0);
        beat(mk(32'h4, 8'hEE, 16'h0), 8'd7, 1'b1);
        chk("mp_no_push", 64'(f_count), 64'd4);
        chk("mp_last_fwd", m_tdata, mk(32'h4, 8'hEE, 16'h0));
        s_tdata  = mk(32'h5, 8'h50, 16'h0);
        s_tlast  = 1'b1;
        s_tvalid = 1'b1;
        #1;
        chk("mp_next_stall", 64'(s_tready), 64'd0);
        s_tvalid = 1'b0;
        f_tready = 1'b1;
        chk("mp_h0", 64'(f_tdata), 64'h43);
        tick();
        chk("mp_h1", 64'(f_tdata), 64'h44);
        tick();
        chk("mp_h2", 64'(f_tdata), 64'h45);
        tick();
        chk("mp_h3", 64'(f_tdata), 64'h4F);
        chk("mp_h3_tid", 64'(f_tid), 64'd7);
        tick();
        chk("mp_drained", 64'(f_count), 64'd0);

        // m_axis backpressure mid-packet
        beat(64'hA1A1_A1A1_A1A1_A1A1, 8'd9, 1'b0);
        m_tready = 1'b0;
        s_tdata  = 64'hA2A2_A2A2_A2A2_A2A2;
        s_tlast  = 1'b0;
        s_tvalid = 1'b1;
        #1;
        chk("mb_ready0", 64'(s_tready), 64'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("mb_hold_data", m_tdata, 64'hA1A1_A1A1_A1A1_A1A1);
            chk("mb_hold_vld",  64'(m_tvalid), 64'd1);
            chk("mb_hold_rdy",  64'(s_tready), 64'd0);
        end
        m_tready = 1'b1;
        #1;
        chk("mb_ready1", 64'(s_tready), 64'd1);
        tick();
        s_tvalid = 1'b0;
        chk("mb_b1", m_tdata, 64'hA2A2_A2A2_A2A2_A2A2);
        beat(64'hA3A3_A3A3_A3A3_A3A3, 8'd9, 1'b1);
        chk("mb_b2", m_tdata, 64'hA3A3_A3A3_A3A3_A3A3);
        tick();
        chk("mb_done", 64'(m_tvalid), 64'd0);

        // Reset mid-packet with fields queued
        f_tready = 1'b0;
        beat(mk(32'h0, 8'h61, 16'h0), 8'd1, 1'b1);
        beat(mk(32'h0, 8'h62, 16'h0), 8'd2, 1'b0);
        chk("rm_count2", 64'(f_count), 64'd2);
        beat(mk(32'h0, 8'h77, 16'h0), 8'd2, 1'b0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rm_m_tvalid", 64'(m_tvalid), 64'd0);
        chk("rm_f_tvalid", 64'(f_tvalid), 64'd0);
        chk("rm_count0",   64'(f_count),  64'd0);
        beat(mk(32'h0, 8'h5C, 16'h0), 8'd3, 1'b0);
        chk("rm_f_valid", 64'(f_tvalid), 64'd1);
        chk("rm_f_data",  64'(f_tdata),  64'h5C);
        chk("rm_count1",  64'(f_count),  64'd1);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
